automat_bauturi_param: RTL and testbench



---
 rtl/automat_bauturi_param.sv | 149 ++++++++++++++
 tb/tb_automat_bauturi_param.sv | 137 +++++++++++++
 2 files changed

// File: rtl/automat_bauturi_param.sv
// Parametrised two-coin vending machine: saturating credit, N_PROD priced products, 1-leu change train.
// Optional macro CANCEL_EN adds a 'cancel' input that refunds the full credit from ACCUM.
module automat_bauturi_param #(
    parameter int                          N_PROD     = 2,
    parameter int                          PRICE_W    = 4,
    parameter logic [N_PROD*PRICE_W-1:0]   PRICES     = {4'd4, 4'd3},
    parameter int                          CREDIT_W   = 4,
    parameter int                          MAX_CREDIT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                B1leu,
    input  logic                B5lei,
    input  logic [N_PROD-1:0]   sel,
`ifdef CANCEL_EN
    input  logic                cancel,
`endif
    output logic [N_PROD-1:0]   cafea,
    output logic                rest,
    output logic                coin_reject,
    output logic                insufficient,
    output logic [CREDIT_W-1:0] credit
);

    localparam int IDX_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;
    localparam int CMP_W = ((PRICE_W > CREDIT_W) ? PRICE_W : CREDIT_W) + 1;
    localparam int SUM_W = (CREDIT_W + 1 > 4) ? CREDIT_W + 1 : 4;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_VEND, S_CHANGE} state_t;

    state_t               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [IDX_W-1:0]     sel_idx_q, sel_idx_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 insufficient_q, insufficient_d;

    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [CMP_W-1:0]     price_sel, price_vend, credit_ext, credit_left;
    logic [2:0]           add;
    logic [SUM_W-1:0]     sum;
    logic                 any_coin;
    logic                 cancel_req;

    function automatic logic [CMP_W-1:0] price_at(input logic [IDX_W-1:0] idx);
        price_at = '0;
        for (int i = 0; i < N_PROD; i++)
            if (idx == IDX_W'(i)) price_at = CMP_W'(PRICES[i*PRICE_W +: PRICE_W]);
    endfunction

    // Lowest set select bit wins when several keys are pressed together.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = N_PROD - 1; i >= 0; i--) begin
            if (sel[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        price_sel   = price_at(sel_idx);
        price_vend  = price_at(sel_idx_q);
        credit_ext  = CMP_W'(credit_q);
        credit_left = credit_ext - price_vend;
        add         = (B5lei ? 3'd5 : 3'd0) + (B1leu ? 3'd1 : 3'd0);
        sum         = SUM_W'(credit_q) + SUM_W'(add);
        any_coin    = B1leu | B5lei;
`ifdef CANCEL_EN
        cancel_req  = cancel;
`else
        cancel_req  = 1'b0;
`endif
    end

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        sel_idx_d      = sel_idx_q;
        coin_reject_d  = 1'b0;
        insufficient_d = 1'b0;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (cancel_req && state_q == S_ACCUM) begin
                    state_d       = S_CHANGE;
                    coin_reject_d = any_coin;
                end else if (sel_found && credit_ext >= price_sel) begin
                    state_d       = S_VEND;
                    sel_idx_d     = sel_idx;
                    coin_reject_d = any_coin;
                end else begin
                    // A refused select still lets coins in this cycle through.
                    insufficient_d = sel_found;
                    if (sum <= SUM_W'(MAX_CREDIT)) begin
                        credit_d = CREDIT_W'(sum);
                        if (sum != '0) state_d = S_ACCUM;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            S_VEND: begin
                credit_d      = CREDIT_W'(credit_left);
                state_d       = (credit_left != '0) ? S_CHANGE : S_IDLE;
                coin_reject_d = any_coin;
            end
            S_CHANGE: begin
                credit_d      = credit_q - 1'b1;
                if (credit_q <= CREDIT_W'(1)) state_d = S_IDLE;
                coin_reject_d = any_coin;
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            sel_idx_q      <= '0;
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            sel_idx_q      <= sel_idx_d;
            coin_reject_q  <= coin_reject_d;
            insufficient_q <= insufficient_d;
        end
    end

    // Dispense and change strobes are pure functions of state, so they can never overlap.
    always_comb begin
        cafea = '0;
        for (int i = 0; i < N_PROD; i++)
            cafea[i] = (state_q == S_VEND) && (sel_idx_q == IDX_W'(i));
    end

    assign rest         = (state_q == S_CHANGE);
    assign coin_reject  = coin_reject_q;
    assign insufficient = insufficient_q;
    assign credit       = credit_q;

endmodule

// File: tb/tb_automat_bauturi_param.sv
// Directed self-checking bench for automat_bauturi_param (default parameters: prices p0=3, p1=4).
module tb_automat_bauturi_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       B1leu = 1'b0, B5lei = 1'b0;
    logic [1:0] sel = '0;
`ifdef CANCEL_EN
    logic       cancel = 1'b0;
`endif
    logic [1:0] cafea;
    logic       rest, coin_reject, insufficient;
    logic [3:0] credit;

    int n_cmp = 0;
    int n_bad = 0;

    automat_bauturi_param dut (
        .clk(clk), .reset(reset), .B1leu(B1leu), .B5lei(B5lei), .sel(sel),
`ifdef CANCEL_EN
        .cancel(cancel),
`endif
        .cafea(cafea), .rest(rest), .coin_reject(coin_reject),
        .insufficient(insufficient), .credit(credit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply inputs for one edge, then sample 1 time unit after it.
    task automatic step(input logic b1, input logic b5, input logic [1:0] s);
        B1leu = b1; B5lei = b5; sel = s;
        @(posedge clk); #1;
        B1leu = 1'b0; B5lei = 1'b0; sel = '0;
    endtask

    task automatic drain(output int n, output int n_cafea);
        n = 0; n_cafea = 0;
        while (rest === 1'b1 && n < 40) begin
            n++;
            if (cafea != 2'b00) n_cafea++;
            step(1'b0, 1'b0, 2'b00);
        end
    endtask

    initial begin
        int n, nc;

        // 1: reset with noise on the inputs
        for (int i = 0; i < 2; i++) begin
            B1leu = 1'($urandom); B5lei = 1'($urandom); sel = 2'($urandom);
            @(posedge clk); #1;
            chk("rst_hold", {cafea, rest, coin_reject, insufficient, credit}, 0);
        end
        reset = 1'b0;
        step(1'b0, 1'b0, 2'b00);
        chk("rst_after", {cafea, rest, coin_reject, insufficient, credit}, 0);

        // 2: three 1-leu coins, buy product 0 (price 3), no change
        step(1'b1, 1'b0, 2'b00); chk("t2_c1", credit, 1);
        step(1'b1, 1'b0, 2'b00); chk("t2_c2", credit, 2);
        step(1'b1, 1'b0, 2'b00); chk("t2_c3", credit, 3);
        step(1'b0, 1'b0, 2'b01); chk("t2_cafea", cafea, 1); chk("t2_rest_v", rest, 0);
        step(1'b0, 1'b0, 2'b00); chk("t2_cafea_off", cafea, 0); chk("t2_rest", rest, 0);
        chk("t2_credit", credit, 0);

        // 3: 5 lei, buy product 1 (price 4), one change pulse
        step(1'b0, 1'b1, 2'b00); chk("t3_c5", credit, 5);
        step(1'b0, 1'b0, 2'b10); chk("t3_cafea", cafea, 2);
        step(1'b0, 1'b0, 2'b00); chk("t3_rest1", rest, 1); chk("t3_cafea_off", cafea, 0);
        chk("t3_credit1", credit, 1);
        step(1'b0, 1'b0, 2'b00); chk("t3_rest0", rest, 0); chk("t3_credit0", credit, 0);

        // 4: insufficient credit, then two keys with product 0 winning
        step(1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b0, 2'b00); chk("t4_c2", credit, 2);
        step(1'b0, 1'b0, 2'b01); chk("t4_insuf", insufficient, 1); chk("t4_credit", credit, 2);
        chk("t4_no_cafea", cafea, 0);
        step(1'b1, 1'b0, 2'b00); chk("t4_insuf_off", insufficient, 0); chk("t4_c3", credit, 3);
        step(1'b0, 1'b0, 2'b11); chk("t4_cafea_lo", cafea, 1);
        step(1'b0, 1'b0, 2'b00); chk("t4_credit0", credit, 0); chk("t4_rest", rest, 0);

        // 5: double coin, overflow reject, coin during change
        step(1'b1, 1'b1, 2'b00); chk("t5_c6", credit, 6);
        step(1'b0, 1'b1, 2'b00); chk("t5_c11", credit, 11);
        step(1'b1, 1'b0, 2'b00); chk("t5_c12", credit, 12); chk("t5_rej_none", coin_reject, 0);
        step(1'b0, 1'b1, 2'b00); chk("t5_rej", coin_reject, 1); chk("t5_c12_hold", credit, 12);
        step(1'b0, 1'b0, 2'b00); chk("t5_rej_off", coin_reject, 0);
        step(1'b0, 1'b0, 2'b10); chk("t5_cafea", cafea, 2);
        step(1'b0, 1'b0, 2'b00); chk("t5_rest", rest, 1); chk("t5_c8", credit, 8);
        step(1'b1, 1'b0, 2'b00); chk("t5_rej_chg", coin_reject, 1); chk("t5_c7", credit, 7);
        drain(n, nc);
        chk("t5_rest_cnt", n, 7); chk("t5_end_credit", credit, 0); chk("t5_overlap", nc, 0);

        // 6: full credit, reset mid-change
        step(1'b0, 1'b1, 2'b00);
        step(1'b0, 1'b1, 2'b00);
        step(1'b0, 1'b1, 2'b00); chk("t6_c15", credit, 15);
        step(1'b0, 1'b0, 2'b01); chk("t6_cafea", cafea, 1);
        step(1'b0, 1'b0, 2'b00); chk("t6_rest1", rest, 1); chk("t6_c12", credit, 12);
        step(1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 2'b00); chk("t6_rest4", rest, 1); chk("t6_c9", credit, 9);
        reset = 1'b1;
        step(1'b0, 1'b0, 2'b00);
        chk("t6_rst", {cafea, rest, coin_reject, insufficient, credit}, 0);
        reset = 1'b0;
        step(1'b0, 1'b0, 2'b00); chk("t6_idle", {rest, credit}, 0);

`ifdef CANCEL_EN
        cancel = 1'b1;
        step(1'b0, 1'b0, 2'b00); cancel = 1'b0;
        chk("c_idle_ignored", rest, 0);
        step(1'b0, 1'b1, 2'b00);
        step(1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b0, 2'b00); chk("c_c7", credit, 7);
        cancel = 1'b1; sel = 2'b01;
        B1leu = 1'b1; B5lei = 1'b0;
        @(posedge clk); #1;
        cancel = 1'b0; sel = '0; B1leu = 1'b0;
        chk("c_rest", rest, 1); chk("c_rej", coin_reject, 1); chk("c_no_cafea", cafea, 0);
        drain(n, nc);
        chk("c_rest_cnt", n, 7); chk("c_cafea_cnt", nc, 0); chk("c_credit0", credit, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
